// File: rtl/qspi_flash_responder_if.sv
// rtl/qspi_flash_responder_if.sv - QSPI bus between quad-read master and flash responder
interface qspi_flash_responder_if;
    logic       sck;
    logic       ce_n;
    logic [3:0] din;
    logic [3:0] dout;
    logic       douten;

    modport master (
        output sck,
        output ce_n,
        output din,
        input  dout,
        input  douten
    );

    modport slave (
        input  sck,
        input  ce_n,
        input  din,
        output dout,
        output douten
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - QSPI flash responder: EBh quad I/O read with continuous mode, 66h/99h reset
module qspi_flash_responder #(
    parameter int ADDR_W       = 24,
    parameter int RST_RECOVERY = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    qspi_flash_responder_if.slave bus,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  cont_mode,
    output logic                  busy
);
    localparam int RC_W = $clog2(RST_RECOVERY) + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_SINK, ST_RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic              sck_q, sck_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [1:0]        mode_q, mode_d;
    logic [23:0]       addr_q, addr_d;
    logic [7:0]        sh_q, sh_d;
    logic [7:0]        next_q, next_d;
    logic              phase_q, phase_d;
    logic              rst_en_q, rst_en_d;
    logic              rd_pend_q, rd_pend_d;
    logic [3:0]        dout_q, dout_d;
    logic              douten_q, douten_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              cont_mode_q, cont_mode_d;
    logic              busy_q, busy_d;
    logic              rise, fall;
    logic [7:0]        cmd_w;

    assign rise = bus.sck & ~sck_q;
    assign fall = ~bus.sck & sck_q;

    always_comb begin
        state_d     = state_q;
        sck_d       = bus.sck;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        sh_d        = sh_q;
        phase_d     = phase_q;
        rst_en_d    = rst_en_q;
        dout_d      = dout_q;
        douten_d    = douten_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        cont_mode_d = cont_mode_q;
        busy_d      = busy_q;
        rd_pend_d   = mem_rd_q;
        // Forward the returning byte so a fall landing on the capture clk still sees it
        next_d      = rd_pend_q ? mem_rdata : next_q;
        cmd_w       = {cmd_q, bus.din[0]};

        if (state_q == ST_RECOVER) begin
            busy_d      = 1'b1;
            cont_mode_d = 1'b0;
            douten_d    = 1'b0;
            dout_d      = 4'h0;
            if (rcnt_q == RC_W'(RST_RECOVERY - 1)) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rcnt_d  = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (bus.ce_n) begin
            state_d  = ST_IDLE;
            cnt_d    = 3'd0;
            phase_d  = 1'b0;
            douten_d = 1'b0;
            dout_d   = 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) begin
                    cnt_d = 3'd1;
                    if (cont_mode_q) begin
                        state_d = ST_ADDR;
                        addr_d  = {20'h0, bus.din};
                    end else begin
                        state_d = ST_CMD;
                        cmd_d   = {6'h0, bus.din[0]};
                    end
                end
                ST_CMD: if (rise) begin
                    cmd_d = cmd_w[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d    = 3'd0;
                        rst_en_d = 1'b0;
                        state_d  = ST_SINK;
                        case (cmd_w)
                            8'hEB: state_d = ST_ADDR;
                            8'h66: rst_en_d = 1'b1;
                            8'h99: if (rst_en_q) begin
                                state_d     = ST_RECOVER;
                                busy_d      = 1'b1;
                                cont_mode_d = 1'b0;
                                rcnt_d      = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ADDR: if (rise) begin
                    addr_d = {addr_q[19:0], bus.din};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        cnt_d      = 3'd0;
                        state_d    = ST_MODE;
                        mem_addr_d = ADDR_W'(addr_d);
                        mem_rd_d   = 1'b1;
                    end
                end
                ST_MODE: if (rise) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd0) begin
                        mode_d = bus.din[1:0];
                    end else begin
                        cnt_d       = 3'd0;
                        state_d     = ST_DUMMY;
                        cont_mode_d = (mode_q == 2'b10);
                    end
                end
                ST_DUMMY: if (rise) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = ST_DATA;
                        phase_d = 1'b0;
                        sh_d    = next_d;
                    end
                end
                ST_DATA: if (fall) begin
                    douten_d = 1'b1;
                    if (!phase_q) begin
                        dout_d     = sh_q[7:4];
                        addr_d     = addr_q + 24'd1;
                        mem_addr_d = ADDR_W'(addr_d);
                        mem_rd_d   = 1'b1;
                        phase_d    = 1'b1;
                    end else begin
                        dout_d  = sh_q[3:0];
                        sh_d    = next_d;
                        phase_d = 1'b0;
                    end
                end
                ST_SINK: begin
                    douten_d = 1'b0;
                    dout_d   = 4'h0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sck_q       <= 1'b0;
            cnt_q       <= 3'd0;
            rcnt_q      <= '0;
            cmd_q       <= 7'h0;
            mode_q      <= 2'b00;
            addr_q      <= 24'h0;
            sh_q        <= 8'h0;
            next_q      <= 8'h0;
            phase_q     <= 1'b0;
            rst_en_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            dout_q      <= 4'h0;
            douten_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            cont_mode_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            sh_q        <= sh_d;
            next_q      <= next_d;
            phase_q     <= phase_d;
            rst_en_q    <= rst_en_d;
            rd_pend_q   <= rd_pend_d;
            dout_q      <= dout_d;
            douten_q    <= douten_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            cont_mode_q <= cont_mode_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.douten = douten_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign cont_mode  = cont_mode_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb/tb_qspi_flash_responder.sv - self-checking bench for qspi_flash_responder
module tb_qspi_flash_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        cont_mode;
    logic        busy;
    logic [7:0]  salt;
    int          checks;
    int          errors;
    int          H;
    logic        model_cont;
    int          busy_cnt;
    int          de_cnt;
    int          inv_bad;
    logic [23:0] rd_log[$];

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  mode;
        int          n;
        logic [7:0]  exp_first;
        logic        exp_cont;
    } vec_t;
    vec_t vt[6];

    qspi_flash_responder_if bus();

    qspi_flash_responder #(.ADDR_W(24), .RST_RECOVERY(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .cont_mode (cont_mode),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [23:0] a);
        return a[7:0] ^ 8'h5A ^ (salt & a[15:8]);
    endfunction

    // Backing memory with one-clk read latency, plus bus activity monitors
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= memf(mem_addr);
            rd_log.push_back(mem_addr);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (bus.douten) de_cnt <= de_cnt + 1;
        if (!bus.douten && bus.dout != 4'h0) inv_bad <= inv_bad + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [3:0] d, output logic [3:0] q, output logic de);
        bus.din = d;
        bus.sck = 1'b0;
        repeat (H) @(negedge clk);
        q  = bus.dout;
        de = bus.douten;
        bus.sck = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic begin_frame();
        @(negedge clk);
        bus.ce_n = 1'b0;
        bus.sck  = 1'b0;
    endtask

    task automatic end_frame();
        bus.ce_n = 1'b1;
        bus.sck  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        logic [3:0] q;
        logic       de;
        for (int i = 7; i >= 0; i--) tick({3'b000, b[i]}, q, de);
    endtask

    task automatic read_txn(input logic [23:0] addr, input logic [7:0] mode, input int n,
                            output logic [7:0] first);
        logic [3:0]  q, hi, lo;
        logic        de;
        logic [23:0] a;
        logic [7:0]  expb;
        int          base;
        base  = rd_log.size();
        first = 8'h00;
        begin_frame();
        if (!model_cont) send_cmd(8'hEB);
        for (int i = 5; i >= 0; i--) tick(addr[4*i +: 4], q, de);
        tick(mode[7:4], q, de);
        tick(mode[3:0], q, de);
        model_cont = (mode[5:4] == 2'b10);
        chk("cont_after_mode", 32'(cont_mode), 32'(model_cont));
        for (int i = 0; i < 4; i++) tick(4'h0, q, de);
        chk("douten_before_data", 32'(de), 32'd0);
        for (int i = 0; i < n; i++) begin
            tick(4'h0, hi, de);
            if (i == 0) chk("douten_first_fall", 32'(de), 32'd1);
            tick(4'h0, lo, de);
            a    = addr + 24'(i);
            expb = memf(a);
            chk("data_byte", 32'({hi, lo}), 32'(expb));
            if (i == 0) first = {hi, lo};
        end
        end_frame();
        chk("rd_count", 32'(rd_log.size() - base), 32'(n + 1));
        if (rd_log.size() > base) chk("rd_first_addr", 32'(rd_log[base]), 32'(addr));
    endtask

    initial begin
        logic [7:0]  fb;
        logic [3:0]  q;
        logic        de;
        logic [23:0] a6, ra;
        logic [7:0]  rm;
        int          base, bb, db;

        salt       = 8'h00;
        model_cont = 1'b0;
        H          = 2;
        rst        = 1'b1;
        bus.ce_n   = 1'b1;
        bus.sck    = 1'b0;
        bus.din    = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_douten", 32'(bus.douten), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cont_mode", 32'(cont_mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vt[0] = '{24'h000100, 8'hA5, 16, 8'h5A, 1'b1};
        vt[1] = '{24'h000200, 8'hA5, 4,  8'h5A, 1'b1};
        vt[2] = '{24'h000300, 8'h00, 4,  8'h5A, 1'b0};
        vt[3] = '{24'h000010, 8'h20, 3,  8'h4A, 1'b1};
        vt[4] = '{24'h0000FF, 8'h30, 2,  8'hA5, 1'b0};
        vt[5] = '{24'hFFFFFF, 8'hA5, 2,  8'hA5, 1'b1};
        for (int k = 0; k < 6; k++) begin
            base = rd_log.size();
            read_txn(vt[k].addr, vt[k].mode, vt[k].n, fb);
            chk("vec_first_byte", 32'(fb), 32'(vt[k].exp_first));
            chk("vec_cont_mode", 32'(cont_mode), 32'(vt[k].exp_cont));
        end
        if (rd_log.size() >= base + 3) begin
            chk("wrap_addr0", 32'(rd_log[base]), 32'hFFFFFF);
            chk("wrap_addr1", 32'(rd_log[base+1]), 32'h000000);
            chk("wrap_addr2", 32'(rd_log[base+2]), 32'h000001);
        end else begin
            chk("wrap_rd_count", 32'(rd_log.size() - base), 32'd3);
        end

        read_txn(24'h000400, 8'h00, 2, fb);
        chk("exit_cont", 32'(cont_mode), 32'd0);
        read_txn(24'h000500, 8'h00, 2, fb);
        chk("after_exit_first", 32'(fb), 32'h5A);

        bb = busy_cnt;
        db = de_cnt;
        begin_frame(); send_cmd(8'h66); end_frame();
        begin_frame(); send_cmd(8'h99);
        chk("busy_set", 32'(busy), 32'd1);
        end_frame();
        repeat (25) @(negedge clk);
        chk("busy_len", 32'(busy_cnt - bb), 32'd16);
        chk("swrst_cont", 32'(cont_mode), 32'd0);
        chk("swrst_douten", 32'(de_cnt - db), 32'd0);
        model_cont = 1'b0;
        bb = busy_cnt;
        begin_frame(); send_cmd(8'h99); end_frame();
        repeat (25) @(negedge clk);
        chk("lone_99_busy", 32'(busy_cnt - bb), 32'd0);

        base = rd_log.size();
        a6   = 24'h123456;
        begin_frame();
        send_cmd(8'hEB);
        for (int i = 5; i >= 3; i--) tick(a6[4*i +: 4], q, de);
        bus.ce_n = 1'b1;
        bus.sck  = 1'b0;
        @(negedge clk);
        chk("abort_douten", 32'(bus.douten), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_rd", 32'(rd_log.size() - base), 32'd0);
        read_txn(24'h000040, 8'h00, 2, fb);
        chk("after_abort_first", 32'(fb), 32'h1A);

        a6 = 24'h000123;
        begin_frame();
        send_cmd(8'hEB);
        for (int i = 5; i >= 0; i--) tick(a6[4*i +: 4], q, de);
        tick(4'hA, q, de);
        tick(4'h5, q, de);
        for (int i = 0; i < 4; i++) tick(4'h0, q, de);
        tick(4'h0, q, de);
        chk("pre_rst_dout", 32'(q), 32'h7);
        chk("pre_rst_cont", 32'(cont_mode), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_dout", 32'(bus.dout), 32'd0);
        chk("mid_rst_douten", 32'(bus.douten), 32'd0);
        chk("mid_rst_cont", 32'(cont_mode), 32'd0);
        chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        rst = 1'b0;
        end_frame();
        model_cont = 1'b0;

        salt = 8'($urandom);
        for (int k = 0; k < 20; k++) begin
            H  = $urandom_range(1, 3);
            ra = 24'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 24'hFFFFFF - 24'($urandom_range(0, 2));
            rm = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rm[5:4] = 2'b10;
            read_txn(ra, rm, $urandom_range(1, 5), fb);
        end

        chk("douten_low_dout_zero", 32'(inv_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
